alu_share_sched: RTL and testbench
==================================

# alu_share_sched

Scheduler that shares one 4-bit ALU datapath in the user project area between two independent requesters. Each requester presents operands and an op select with a valid/ready handshake. The block grants the ALU round-robin, drives the operands for a fixed, parameterised ALU latency, and captures the result. It then returns the result, tagged with the requester ID, over a single response handshake. It sits between the GPIO/logic-analyzer input decode and the shared ALU instance, replacing the two dedicated ALU copies.

## Interface
Parameters:
- DATA_W, 4, operand width
- RES_W, 5, result width as returned by the ALU (DATA_W+1, carry in MSB)
- ALU_LAT, 1, cycles from operand drive to valid alu_y; legal 1..7

Ports:
- clock  in  1  single system clock, all state on rising edge
- resetb  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a, req0_b  in  DATA_W  requester 0 operands
- req0_sel  in  2  requester 0 ALU op select, passed through unmodified
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1
- alu_a, alu_b  out  DATA_W  operands to shared ALU (registered)
- alu_sel  out  2  op select to shared ALU (registered)
- alu_y  in  RES_W  ALU result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester the result belongs to
- rsp_y  out  RES_W  captured result
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Only one op is in flight.
- IDLE:
  - If neither valid is set: stay in IDLE.
  - Else pick the grant: if exactly one valid, grant it; if both, grant the requester not served last (pointer `last`).
  - reqN_ready = (state==IDLE) && grantN, combinational. Acceptance = valid && ready in the same cycle.
  - On acceptance: register the granted a/b/sel into alu_a/alu_b/alu_sel, register the grant into rsp_id, set `last` = grant, load the latency counter with ALU_LAT-1, go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - When counter==0: capture alu_y into rsp_y and go to RESP.
- RESP:
  - rsp_valid=1; rsp_y and rsp_id are stable.
  - On rsp_ready: go to IDLE.
  - rsp_ready is ignored in every other state.
- alu_a/alu_b/alu_sel hold their last accepted values until the next acceptance; they do not return to 0 after an op.
- The ungranted requester's ready stays 0. Its valid/operands may stay asserted indefinitely and are not sampled.
- A valid that drops while not granted is not an error; nothing is latched.
- Reset values: alu_a=alu_b=0, alu_sel=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, state=IDLE, last=1 (so req0 wins the first tie), counter=0.
- Reset asserted mid-operation: the in-flight op is discarded, no response is produced, and all outputs return to their reset values immediately (asynchronous).

## Timing
- Accept edge T (end of the cycle where valid&&ready).
- alu_* are valid from T through the next acceptance.
- EXEC occupies ALU_LAT cycles. alu_y is sampled on edge T+ALU_LAT.
- rsp_valid rises after edge T+ALU_LAT, i.e. visible in cycle T+ALU_LAT+1.
- Response handshake at edge R: IDLE in cycle R+1. Earliest next acceptance is edge R+1.
- Minimum issue-to-issue spacing is ALU_LAT+2 cycles (with rsp_ready held high).
- reqN_ready has a combinational path from reqM_valid (arbitration) only. There is no combinational path from alu_y or rsp_ready to any output.

## Test plan
- Reset/idle: hold resetb=0 for 5 cycles, then release with no valids. All outputs remain 0, busy=0, and req0_ready=req1_ready=0.
- Single op (bench ALU = add for sel=00, ALU_LAT=1):
  - Stimulus: req0 a=9, b=9, sel=00; rsp_ready held high.
  - Required: req0_ready for exactly 1 cycle; alu_a=9, alu_b=9 from the next cycle; rsp_valid, rsp_id=0, rsp_y=5'b10010 two cycles after acceptance.
- Round-robin:
  - Stimulus: both requesters valid continuously (req0 3+4, req1 15+1).
  - Required: grant order req0, req1, req0, req1; responses 7/id0, 16/id1 alternating. The ungranted ready is never high.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles after rsp_valid.
  - Required: rsp_y/rsp_id stay stable, busy=1, no new acceptance; on release, IDLE follows next cycle.
- Latency parameter: ALU_LAT=3 with a bench ALU delayed by 3 cycles. rsp_valid appears exactly 4 cycles after acceptance with the correct result.
- Reset mid-EXEC: assert resetb low during EXEC. All outputs drop to 0 at once and no rsp_valid follows. After release, the first tie is granted to req0.

Source files
------------

// File: rtl/alu_share_sched.sv
// alu_share_sched: time-shares one ALU between two requesters.
// A round-robin arbiter picks a requester in IDLE. The block then holds its
// operands on the ALU for ALU_LAT cycles and captures the result. The result
// is returned, tagged with the requester id, over one response handshake.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. valid must not wait for ready. On the request side, ready
// depends combinationally on both valids (arbitration) and on the registered
// state only. On the response side, rsp_valid comes straight from the state
// register, and rsp_ready never feeds any output combinationally.
module alu_share_sched #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 5,
  parameter int ALU_LAT = 1   // legal range 1..7
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [RES_W-1:0]  alu_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_y,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // A 3-bit counter covers the largest load value, ALU_LAT-1 = 6.
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  state_t           state;
  logic             last;     // requester served most recently
  logic [CNT_W-1:0] cnt;
  logic             grant0;
  logic             grant1;
  logic             accept;

  // Round-robin arbitration: a lone valid wins; on a tie the requester not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last;
      grant1 = !last;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;

  // These are decoded from the state register only, so no input reaches them.
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Main FSM: accept and issue the operands, wait ALU_LAT cycles, capture, then respond.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      last    <= 1'b1;
      cnt     <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rsp_id  <= 1'b0;
      rsp_y   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (grant1) begin
              alu_a   <= req1_a;
              alu_b   <= req1_b;
              alu_sel <= req1_sel;
            end else begin
              alu_a   <= req0_a;
              alu_b   <= req0_b;
              alu_sel <= req0_sel;
            end
            rsp_id <= grant1;
            last   <= grant1;
            cnt    <= CNT_LOAD;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_y <= alu_y;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sched.sv
// Testbench for alu_share_sched. dut_a uses ALU_LAT=1 with a combinational
// bench ALU. dut_b uses ALU_LAT=3 with a bench ALU whose result appears
// three cycles after its operands change. Both DUTs share the request inputs,
// rsp_ready and reset. Each test checks one DUT.
module tb_alu_share_sched;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0] req0_sel = '0, req1_sel = '0;
  logic       rsp_ready = 1'b0;

  logic       a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_id, a_busy;
  logic [3:0] a_alu_a, a_alu_b;
  logic [1:0] a_alu_sel, a_state_dbg;
  logic [4:0] a_alu_y, a_rsp_y;
  logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_busy;
  logic [3:0] b_alu_a, b_alu_b;
  logic [1:0] b_alu_sel, b_state_dbg;
  logic [4:0] b_alu_y, b_rsp_y, b_s1, b_s2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Scoreboard: {id, result} pushed when stimulus is driven.
  logic [5:0] exp_q[$];
  // Observations recorded by the monitors.
  bit         a_grant_q[$], b_grant_q[$];
  int         a_acc_q[$], b_acc_q[$];
  logic [5:0] a_rsp_q[$], b_rsp_q[$];
  int         a_rsp_cyc_q[$], b_rsp_cyc_q[$];
  int         a_r0_cyc, a_bad_rdy, a_vcyc, b_vcyc;

  wire [21:0] a_all = {a_req0_ready, a_req1_ready, a_alu_a, a_alu_b, a_alu_sel, a_rsp_valid,
                       a_rsp_id, a_rsp_y, a_busy, a_state_dbg};
  wire [21:0] b_all = {b_req0_ready, b_req1_ready, b_alu_a, b_alu_b, b_alu_sel, b_rsp_valid,
                       b_rsp_id, b_rsp_y, b_busy, b_state_dbg};

  always #5 clock = ~clock;

  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] sel);
    case (sel)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Bench ALUs: combinational for dut_a; comb plus two register stages for dut_b.
  assign a_alu_y = alu_f(a_alu_a, a_alu_b, a_alu_sel);
  always @(posedge clock) begin
    b_s1 <= alu_f(b_alu_a, b_alu_b, b_alu_sel);
    b_s2 <= b_s1;
  end
  assign b_alu_y = b_s2;

  alu_share_sched #(.DATA_W(4), .RES_W(5), .ALU_LAT(1)) dut_a (
    .clock(clock), .resetb(resetb),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_sel(a_alu_sel), .alu_y(a_alu_y),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id), .rsp_y(a_rsp_y),
    .busy(a_busy), .state_dbg(a_state_dbg)
  );

  alu_share_sched #(.DATA_W(4), .RES_W(5), .ALU_LAT(3)) dut_b (
    .clock(clock), .resetb(resetb),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_sel(b_alu_sel), .alu_y(b_alu_y),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_y(b_rsp_y),
    .busy(b_busy), .state_dbg(b_state_dbg)
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor for dut_a: records acceptances and responses at the falling edge.
  always @(negedge clock) begin
    if (resetb) begin
      if (req0_valid && a_req0_ready) begin a_grant_q.push_back(1'b0); a_acc_q.push_back(cyc); end
      if (req1_valid && a_req1_ready) begin a_grant_q.push_back(1'b1); a_acc_q.push_back(cyc); end
      if (a_req0_ready) a_r0_cyc++;
      if ((a_req0_ready && a_req1_ready) || (a_req0_ready && !req0_valid) ||
          (a_req1_ready && !req1_valid)) a_bad_rdy++;
      if (a_rsp_valid) a_vcyc++;
      if (a_rsp_valid && rsp_ready) begin
        a_rsp_q.push_back({a_rsp_id, a_rsp_y});
        a_rsp_cyc_q.push_back(cyc);
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clock) begin
    if (resetb) begin
      if (req0_valid && b_req0_ready) begin b_grant_q.push_back(1'b0); b_acc_q.push_back(cyc); end
      if (req1_valid && b_req1_ready) begin b_grant_q.push_back(1'b1); b_acc_q.push_back(cyc); end
      if (b_rsp_valid) b_vcyc++;
      if (b_rsp_valid && rsp_ready) begin
        b_rsp_q.push_back({b_rsp_id, b_rsp_y});
        b_rsp_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_obs();
    exp_q.delete();
    a_grant_q.delete(); b_grant_q.delete();
    a_acc_q.delete(); b_acc_q.delete();
    a_rsp_q.delete(); b_rsp_q.delete();
    a_rsp_cyc_q.delete(); b_rsp_cyc_q.delete();
    a_r0_cyc = 0; a_bad_rdy = 0; a_vcyc = 0; b_vcyc = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    resetb = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetb = 1'b1;
    clear_obs();
  endtask

  // Driver: present one op and hold it until the chosen DUT accepts it.
  task automatic send(input bit use_b, input bit id, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] sel);
    bit got = 1'b0;
    bit rdy;
    int n = 0;
    exp_q.push_back({id, alu_f(a, b, sel)});
    @(posedge clock); #1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; end
    while (!got && n < 50) begin
      @(negedge clock);
      rdy = id ? (use_b ? b_req1_ready : a_req1_ready) : (use_b ? b_req0_ready : a_req0_ready);
      if (rdy) got = 1'b1;
      n++;
    end
    @(posedge clock); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL send_accept: id=%0d never accepted in 50 cycles", id); end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (5) @(posedge clock);
    #1 resetb = 1'b1;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (a_all !== 22'd0) begin bad++; $display("FAIL reset_idle_a: got=%h exp=0", a_all); end
      total++;
      if (b_all !== 22'd0) begin bad++; $display("FAIL reset_idle_b: got=%h exp=0", b_all); end
    end
  endtask

  task automatic test_single();
    int n = 0;
    logic [5:0] got, exp;
    do_reset();
    rsp_ready = 1'b1;
    send(1'b0, 1'b0, 4'd9, 4'd9, 2'b00);
    // Change the request operands so only the registered copy can show 9.
    req0_a = 4'd1; req0_b = 4'd2;
    @(negedge clock);
    total++;
    if ({a_alu_a, a_alu_b, a_alu_sel} !== {4'd9, 4'd9, 2'b00}) begin
      bad++; $display("FAIL single_alu_ops: got=%h exp=%h", {a_alu_a, a_alu_b, a_alu_sel}, {4'd9, 4'd9, 2'b00});
    end
    while (a_rsp_q.size() < 1 && n < 20) begin @(negedge clock); #1; n++; end
    total++;
    if (a_rsp_q.size() != 1 || exp_q.size() != 1) begin
      bad++; $display("FAIL single_rsp: got %0d responses exp 1", a_rsp_q.size());
    end else begin
      got = a_rsp_q.pop_front(); exp = exp_q.pop_front();
      if (got !== exp) begin bad++; $display("FAIL single_rsp: got=%h exp=%h", got, exp); end
    end
    total++;
    if (a_rsp_cyc_q.size() != 1 || a_acc_q.size() != 1 || a_rsp_cyc_q[0] - a_acc_q[0] != 2) begin
      bad++; $display("FAIL single_latency: rsp/acc queues %0d/%0d exp gap 2", a_rsp_cyc_q.size(), a_acc_q.size());
    end
    total++;
    if (a_r0_cyc != 1) begin bad++; $display("FAIL single_ready_cycles: got=%0d exp=1", a_r0_cyc); end
    repeat (3) @(negedge clock);
    total++;
    if ({a_alu_a, a_alu_b, a_busy, a_rsp_valid} !== {4'd9, 4'd9, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_hold: got=%h exp=%h", {a_alu_a, a_alu_b, a_busy, a_rsp_valid}, {4'd9, 4'd9, 2'b00});
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    logic [5:0] got, exp;
    bit g;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, alu_f(4'd3, 4'd4, 2'b00)});
      exp_q.push_back({1'b1, alu_f(4'd15, 4'd1, 2'b00)});
    end
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd4; req0_sel = 2'b00;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd1; req1_sel = 2'b00;
    while (a_rsp_q.size() < 4 && n < 100) begin @(negedge clock); #1; n++; end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (a_grant_q.size() != 4) begin bad++; $display("FAIL rr_grant_count: got=%0d exp=4", a_grant_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (a_grant_q.size() == 0) begin
        bad++; $display("FAIL rr_grant_order: missing grant %0d", i);
      end else begin
        g = a_grant_q.pop_front();
        if (g !== i[0]) begin bad++; $display("FAIL rr_grant_order: slot %0d got=%0d exp=%0d", i, g, i[0]); end
      end
      total++;
      if (a_rsp_q.size() == 0 || exp_q.size() == 0) begin
        bad++; $display("FAIL rr_rsp: missing response %0d", i);
      end else begin
        got = a_rsp_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin bad++; $display("FAIL rr_rsp: slot %0d got=%h exp=%h", i, got, exp); end
      end
    end
    total++;
    if (a_bad_rdy != 0) begin bad++; $display("FAIL rr_ungranted_ready: got=%0d cycles exp=0", a_bad_rdy); end
    total++;
    if (a_acc_q.size() < 2 || a_acc_q[1] - a_acc_q[0] != 3) begin
      bad++; $display("FAIL rr_issue_spacing: got size %0d exp gap 3", a_acc_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [5:0] got, exp;
    do_reset();
    rsp_ready = 1'b0;
    send(1'b0, 1'b0, 4'd5, 4'd6, 2'b10);
    while (!a_rsp_valid && n < 20) begin @(negedge clock); n++; end
    @(posedge clock); #1;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd8; req1_sel = 2'b11;
    exp_q.push_back({1'b1, alu_f(4'd7, 4'd8, 2'b11)});
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if ({a_rsp_valid, a_rsp_id, a_rsp_y, a_busy, a_req0_ready, a_req1_ready} !==
          {1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0}) begin
        bad++; $display("FAIL bp_stall: cycle %0d got=%h exp=%h", i,
          {a_rsp_valid, a_rsp_id, a_rsp_y, a_busy, a_req0_ready, a_req1_ready},
          {1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0});
      end
    end
    total++;
    if (a_grant_q.size() != 1) begin bad++; $display("FAIL bp_no_accept: grants=%0d exp=1", a_grant_q.size()); end
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    total++;
    if ({a_state_dbg, a_busy, a_req1_ready, a_rsp_valid} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL bp_release_idle: got=%b exp=%b", {a_state_dbg, a_busy, a_req1_ready, a_rsp_valid}, 5'b00010);
    end
    @(posedge clock); #1 req1_valid = 1'b0;
    n = 0;
    while (a_rsp_q.size() < 2 && n < 20) begin @(negedge clock); #1; n++; end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (a_rsp_q.size() == 0 || exp_q.size() == 0) begin
        bad++; $display("FAIL bp_rsp: missing response %0d", i);
      end else begin
        got = a_rsp_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin bad++; $display("FAIL bp_rsp: slot %0d got=%h exp=%h", i, got, exp); end
      end
    end
  endtask

  task automatic test_latency();
    int n = 0;
    logic [5:0] got, exp;
    do_reset();
    rsp_ready = 1'b1;
    send(1'b1, 1'b0, 4'd12, 4'd7, 2'b00);
    send(1'b1, 1'b1, 4'd3, 4'd5, 2'b01);
    while (b_rsp_q.size() < 2 && n < 60) begin @(negedge clock); #1; n++; end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (b_rsp_q.size() == 0 || exp_q.size() == 0 || b_acc_q.size() <= i || b_rsp_cyc_q.size() == 0) begin
        bad++; $display("FAIL lat3_rsp: missing response %0d", i);
      end else begin
        got = b_rsp_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin bad++; $display("FAIL lat3_rsp: slot %0d got=%h exp=%h", i, got, exp); end
        if (b_rsp_cyc_q[0] - b_acc_q[i] != 4) begin
          bad++; $display("FAIL lat3_delay: slot %0d got=%0d exp=4", i, b_rsp_cyc_q[0] - b_acc_q[i]);
        end
        void'(b_rsp_cyc_q.pop_front());
      end
    end
    total++;
    if (b_acc_q.size() < 2 || b_acc_q[1] - b_acc_q[0] != 5) begin
      bad++; $display("FAIL lat3_issue_spacing: size %0d exp gap 5", b_acc_q.size());
    end
  endtask

  task automatic test_reset_mid_exec();
    int n = 0;
    bit got = 1'b0;
    do_reset();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_sel = 2'b00;
    while (!got && n < 20) begin @(negedge clock); if (a_req0_ready) got = 1'b1; n++; end
    @(posedge clock); #2;
    req0_valid = 1'b0;
    resetb = 1'b0;
    #1;
    total++;
    if (a_all !== 22'd0) begin bad++; $display("FAIL midexec_reset_a: got=%h exp=0", a_all); end
    total++;
    if (b_all !== 22'd0) begin bad++; $display("FAIL midexec_reset_b: got=%h exp=0", b_all); end
    repeat (2) @(posedge clock);
    #1 resetb = 1'b1;
    clear_obs();
    repeat (6) @(negedge clock);
    total++;
    if (a_vcyc != 0 || b_vcyc != 0) begin
      bad++; $display("FAIL midexec_no_rsp: rsp_valid cycles a=%0d b=%0d exp 0", a_vcyc, b_vcyc);
    end
    @(posedge clock); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (a_grant_q.size() == 0 && n < 20) begin @(negedge clock); #1; n++; end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++;
    if (a_grant_q.size() == 0) begin
      bad++; $display("FAIL midexec_first_tie: no grant, exp req0");
    end else if (a_grant_q[0] !== 1'b0) begin
      bad++; $display("FAIL midexec_first_tie: got=%0d exp=0", a_grant_q[0]);
    end
    repeat (8) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
